// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with hold, jump, relative branch, and call/return
// through an internal LIFO of return addresses with sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hold,
    input  logic                               jump,
    input  logic [ADDR_WIDTH-1:0]              jump_addr,
    input  logic                               branch,
    input  logic [ADDR_WIDTH-1:0]              branch_off,
    input  logic                               call,
    input  logic                               ret,
    output logic [ADDR_WIDTH-1:0]              pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic [ADDR_WIDTH-1:0] stack_r [SLOTS];

    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  ovf_next_s;
    logic                  unf_next_s;
    logic                  push_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic [IDX_W-1:0]      top_idx_s;
    logic [IDX_W-1:0]      push_idx_s;
    logic                  hold_s;
    logic                  ret_s;
    logic                  call_s;
    logic                  jump_s;
    logic                  branch_s;

    // Unknown request levels must never trigger an action, so only a clean 1 counts.
    assign hold_s   = (hold   === 1'b1);
    assign ret_s    = (ret    === 1'b1);
    assign call_s   = (call   === 1'b1);
    assign jump_s   = (jump   === 1'b1);
    assign branch_s = (branch === 1'b1);

    assign pc_inc_s   = pc_r + ADDR_WIDTH'(1);
    assign top_idx_s  = IDX_W'(cnt_r - CNT_W'(1));
    assign push_idx_s = IDX_W'(cnt_r);

    // Prioritised next-state selection: hold > ret > call > jump > branch > increment.
    always_comb begin
        pc_next_s  = pc_inc_s;
        cnt_next_s = cnt_r;
        ovf_next_s = ovf_r;
        unf_next_s = unf_r;
        push_s     = 1'b0;
        if (hold_s) begin
            pc_next_s = pc_r;
        end else if (ret_s) begin
            if (cnt_r != CNT_W'(0)) begin
                pc_next_s  = stack_r[top_idx_s];
                cnt_next_s = cnt_r - CNT_W'(1);
            end else begin
                unf_next_s = 1'b1;
            end
        end else if (call_s) begin
            pc_next_s = jump_addr;
            if (cnt_r == CNT_W'(STACK_DEPTH)) begin
                ovf_next_s = 1'b1;
            end else begin
                push_s     = 1'b1;
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else if (jump_s) begin
            pc_next_s = jump_addr;
        end else if (branch_s) begin
            pc_next_s = pc_r + branch_off;
        end else begin
            pc_next_s = pc_inc_s;
        end
    end

    // PC, stack depth and sticky flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r  <= RESET_VECTOR;
            cnt_r <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_next_s;
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
            unf_r <= unf_next_s;
        end
    end

    // Return-address storage; cleared on reset so no slot ever holds an unknown value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                stack_r[i] <= '0;
            end
        end else if (push_s) begin
            stack_r[push_idx_s] <= pc_inc_s;
        end else begin
            stack_r <= stack_r;
        end
    end

    assign pc_out      = pc_r;
    assign stack_count = cnt_r;
    assign stack_ovf   = ovf_r;
    assign stack_unf   = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios against fixed expected
// values, then randomized traffic against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int AW  = 8;
    localparam int SD  = 4;
    localparam int CW  = $clog2(SD + 1);
    localparam int MOD = 1 << AW;

    localparam bit [4:0] R_NONE = 5'b00000;
    localparam bit [4:0] R_HOLD = 5'b10000;
    localparam bit [4:0] R_RET  = 5'b01000;
    localparam bit [4:0] R_CALL = 5'b00100;
    localparam bit [4:0] R_JMP  = 5'b00010;
    localparam bit [4:0] R_BR   = 5'b00001;

    typedef struct {
        bit [4:0]      req;
        logic [AW-1:0] ja;
        logic [AW-1:0] bo;
        logic [AW-1:0] pc;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          unf;
    } step_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          hold, jump, branch, call, ret;
    logic [AW-1:0] jump_addr, branch_off;
    logic [AW-1:0] pc_out;
    logic [CW-1:0] stack_count;
    logic          stack_ovf, stack_unf;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned m_pc;
    int unsigned m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    pc_stack_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_VECTOR(8'h00)) dut (
        .clk(clk), .reset(reset), .hold(hold), .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
        .pc_out(pc_out), .stack_count(stack_count), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input bit [4:0] req, input int unsigned ja, input int unsigned bo);
        if (req[4]) return;
        if (req[3]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = (m_pc + 1) % MOD;
                m_unf = 1'b1;
            end
        end else if (req[2]) begin
            if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % MOD);
            else m_ovf = 1'b1;
            m_pc = ja;
        end else if (req[1]) m_pc = ja;
        else if (req[0]) m_pc = (m_pc + bo) % MOD;
        else m_pc = (m_pc + 1) % MOD;
    endfunction

    task automatic drive(input bit [4:0] req, input logic [AW-1:0] ja, input logic [AW-1:0] bo);
        {hold, ret, call, jump, branch} = req;
        jump_addr  = ja;
        branch_off = bo;
        model_step(req, int'(ja), int'(bo));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        step_t t[8];
        logic [AW+CW+1:0] obs, exp;
        {hold, ret, call, jump, branch} = R_NONE;
        jump_addr = '0;
        branch_off = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        obs = {pc_out, stack_count, stack_ovf, stack_unf};
        exp = {8'h00, 3'd0, 1'b0, 1'b0};
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        reset = 1'b1;
        t = '{'{R_NONE, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h03, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h04, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h05, 3'd0, 1'b0, 1'b0},
              '{R_JMP,  8'hFE, 8'h00, 8'hFE, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL increment step %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_jump_branch();
        step_t t[5];
        logic [AW+CW+1:0] obs, exp;
        t = '{'{R_JMP, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0},
              '{R_JMP, 8'h80, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0},
              '{R_BR,  8'h00, 8'hF0, 8'h70, 3'd0, 1'b0, 1'b0},
              '{R_JMP, 8'hF8, 8'h00, 8'hF8, 3'd0, 1'b0, 1'b0},
              '{R_BR,  8'h00, 8'h10, 8'h08, 3'd0, 1'b0, 1'b0}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL jump_branch step %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_nested_call();
        step_t t[7];
        logic [AW+CW+1:0] obs, exp;
        t = '{'{R_JMP,  8'h05, 8'h00, 8'h05, 3'd0, 1'b0, 1'b0},
              '{R_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h41, 3'd1, 1'b0, 1'b0},
              '{R_NONE, 8'h00, 8'h00, 8'h42, 3'd1, 1'b0, 1'b0},
              '{R_CALL, 8'h90, 8'h00, 8'h90, 3'd2, 1'b0, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h43, 3'd1, 1'b0, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h06, 3'd0, 1'b0, 1'b0}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL nested_call step %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_ovf_unf();
        step_t t[10];
        logic [AW+CW+1:0] obs, exp;
        t = '{'{R_CALL, 8'h20, 8'h00, 8'h20, 3'd1, 1'b0, 1'b0},
              '{R_CALL, 8'h30, 8'h00, 8'h30, 3'd2, 1'b0, 1'b0},
              '{R_CALL, 8'h50, 8'h00, 8'h50, 3'd3, 1'b0, 1'b0},
              '{R_CALL, 8'h60, 8'h00, 8'h60, 3'd4, 1'b0, 1'b0},
              '{R_CALL, 8'h70, 8'h00, 8'h70, 3'd4, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h51, 3'd3, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h31, 3'd2, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h21, 3'd1, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h07, 3'd0, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h08, 3'd0, 1'b1, 1'b1}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL ovf_unf step %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_priority();
        step_t t[8];
        logic [AW+CW+1:0] obs, exp;
        pulse_reset();
        t = '{'{R_CALL,                            8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0},
              '{R_HOLD | R_RET | R_CALL | R_JMP,   8'h99, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0},
              '{R_RET | R_CALL | R_JMP,            8'h99, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0},
              '{R_CALL | R_JMP,                    8'h55, 8'h00, 8'h55, 3'd1, 1'b0, 1'b0},
              '{R_JMP | R_BR,                      8'h22, 8'h10, 8'h22, 3'd1, 1'b0, 1'b0},
              '{R_HOLD | R_BR,                     8'h00, 8'h10, 8'h22, 3'd1, 1'b0, 1'b0},
              '{R_BR,                              8'h00, 8'h10, 8'h32, 3'd1, 1'b0, 1'b0},
              '{R_RET,                             8'h00, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL priority step %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        step_t t[6];
        logic [AW+CW+1:0] obs, exp;
        t = '{'{R_CALL, 8'h10, 8'h00, 8'h10, 3'd1, 1'b0, 1'b0},
              '{R_CALL, 8'h20, 8'h00, 8'h20, 3'd2, 1'b0, 1'b0},
              '{R_CALL, 8'h30, 8'h00, 8'h30, 3'd3, 1'b0, 1'b0},
              '{R_CALL, 8'h40, 8'h00, 8'h40, 3'd4, 1'b0, 1'b0},
              '{R_CALL, 8'h50, 8'h00, 8'h50, 3'd4, 1'b1, 1'b0},
              '{R_RET,  8'h00, 8'h00, 8'h31, 3'd3, 1'b1, 1'b0}};
        foreach (t[i]) begin
            drive(t[i].req, t[i].ja, t[i].bo);
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {t[i].pc, t[i].cnt, t[i].ovf, t[i].unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mid_reset setup %0d: got %h expected %h", i, obs, exp);
            end
        end
        {hold, ret, call, jump, branch} = R_NONE;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        obs = {pc_out, stack_count, stack_ovf, stack_unf};
        exp = {8'h00, 3'd0, 1'b0, 1'b0};
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset async: got %h expected %h", obs, exp);
        end
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit [4:0]         req;
        logic [AW+CW+1:0] obs, exp;
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) begin
                {hold, ret, call, jump, branch} = R_NONE;
                pulse_reset();
            end
            req[4] = ($urandom_range(0, 9) == 0);
            req[3] = ($urandom_range(0, 3) == 0);
            req[2] = ($urandom_range(0, 2) == 0);
            req[1] = ($urandom_range(0, 3) == 0);
            req[0] = ($urandom_range(0, 2) == 0);
            drive(req, AW'($urandom), AW'($urandom));
            n_tests++;
            obs = {pc_out, stack_count, stack_ovf, stack_unf};
            exp = {AW'(m_pc), CW'(m_stk.size()), m_ovf, m_unf};
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d req %b: got %h expected %h", i, req, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump_branch();
        test_nested_call();
        test_ovf_unf();
        test_priority();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter for the core fetch stage, and the successor of the 8-bit PC.
- Holds the current fetch address internally; no external feedback of the PC is needed.
- Supports hold, absolute jump, PC-relative branch, subroutine call and return.
- Call and return use an internal return-address stack (LIFO) with sticky overflow and underflow flags.
- Feeds instruction memory address and is driven by the decode/control unit.

Parameters:
ADDR_WIDTH, 8, width of PC, jump/call targets, branch offset and stack entries.
STACK_DEPTH, 4, number of return-address entries (>=1).
RESET_VECTOR, 0, PC value loaded on reset (ADDR_WIDTH bits).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
hold  input  1  freeze PC and stack this cycle.
jump  input  1  absolute jump request.
jump_addr  input  ADDR_WIDTH  absolute jump target.
branch  input  1  relative branch request.
branch_off  input  ADDR_WIDTH  two's-complement offset, relative to current PC.
call  input  1  subroutine call; target is jump_addr.
ret  input  1  return from subroutine.
pc_out  output  ADDR_WIDTH  current fetch address (registered).
stack_count  output  clog2(STACK_DEPTH+1)  valid stack entries.
stack_ovf  output  1  sticky: call issued with stack full.
stack_unf  output  1  sticky: ret issued with stack empty.

Behaviour:
- Reset low, asynchronous, any time including mid-operation:
  - pc_out = RESET_VECTOR, stack_count = 0, stack_ovf = 0, stack_unf = 0.
  - Stack entry contents are don't-care.
  - Reset release takes effect on the next rising clk.
- All updates occur on the rising clk edge. pc_out is registered with 1-cycle latency from request to new PC. No combinational path from inputs to outputs.
- Per-cycle priority (exactly one action taken), highest first:
  1. hold: PC, stack and flags unchanged. All other requests that cycle are ignored, not queued.
  2. ret:
     - stack_count>0: PC <= top entry; stack_count decrements.
     - stack_count==0: PC <= PC+1; stack_unf <= 1.
  3. call: PC <= jump_addr; push PC+1 as return address.
     - Stack full (stack_count==STACK_DEPTH): jump still taken, push discarded, stack contents and count unchanged, stack_ovf <= 1.
  4. jump: PC <= jump_addr.
  5. branch: PC <= PC + branch_off.
  6. none: PC <= PC+1.
- Arithmetic:
  - All sums are modulo 2^ADDR_WIDTH; carry is discarded.
  - PC = all-ones increments to 0.
  - Branch may wrap in either direction.
  - The pushed return address wraps the same way.
- Stack:
  - LIFO, STACK_DEPTH entries × ADDR_WIDTH bits.
  - Top entry is the most recently pushed.
  - stack_count ranges 0..STACK_DEPTH and never wraps.
- Flags are sticky until reset and do not alter subsequent behaviour.
- X/Z on request inputs is treated as 0 (compare against 1'b1 explicitly). This does not apply to reset.

Test Plan:
- Reset and increment: hold reset low, then release with no requests, 5 clocks. Required: pc_out 0 during reset, then 1,2,3,4,5. With ADDR_WIDTH=8 starting at PC=0xFE, pc_out goes 0xFF, then 0x00.
- Jump and branch: at PC=0x10, jump=1 with jump_addr=0x80, giving 0x80. Then branch_off=0xF0 (−16), giving 0x70. At PC=0xF8, branch_off=0x10 wraps to 0x08.
- Nested call/return:
  - At PC=0x05, call to 0x40 gives pc_out 0x40, stack_count 1.
  - At 0x42, call to 0x90 gives stack_count 2.
  - ret gives 0x43; ret again gives 0x06, stack_count 0.
- Overflow and underflow, STACK_DEPTH=4:
  - Five calls: the fifth still jumps, stack_count stays 4, stack_ovf=1.
  - Four rets return the first four return addresses in reverse order.
  - A fifth ret gives PC+1 and stack_unf=1.
- Priority and hold:
  - hold with jump, call and ret all asserted: pc_out and stack_count unchanged.
  - ret+call+jump together with a non-empty stack: ret wins.
  - call+jump: call wins and pushes.
  - jump+branch: jump wins.
- Mid-operation reset: with stack_count=3 and stack_ovf=1, pulse reset low between clock edges. Required: pc_out=RESET_VECTOR, stack_count=0, flags=0 immediately, with no clock edge needed.
